id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ============================================================================
// id_ex_reg -- ID/EX pipeline register with load-use hazard detection
//
// Purpose:
//   Carries a decoded instruction from the decode stage into the execute
//   stage. It detects a load-use hazard between the load already in EX and
//   the instruction sitting in ID. On a hazard it raises a zero-latency
//   stall, which freezes the PC and IF/ID, and it inserts a single bubble.
//   A taken-branch flush squashes the ID instruction. When flush and a
//   hazard occur together, the flush takes priority.
//
// Configuration:
//   ID_EX_PERF_CNT_EN - when defined, stall_count counts inserted load-use
//                       bubbles and saturates at 16'hFFFF. When undefined,
//                       stall_count is tied to 0 and no counter flops exist.
//
// Valid semantics:
//   id_valid / ex_valid qualify the whole stage payload. When valid is 0 the
//   data and register-number fields are don't-care. The side-effecting
//   controls are forced low whenever valid is 0:
//     - ex_MemRead and ex_RegWrite, on every bubble;
//     - ex_ctrl, additionally, on stall and flush bubbles.
//   There is no ready signal. Back-pressure toward the front end is the
//   combinational stall output.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   id_valid                    decode stage holds a real instruction
//   id_ReadData1/2, id_Imm      64-bit operands and sign-extended immediate
//   id_Rn, id_Rm, id_Rd         source/destination register numbers
//   id_MemRead, id_RegWrite     load and register-write controls
//   id_ctrl                     remaining EX/MEM/WB control bits
//   flush                       squash the ID instruction (taken branch)
//   ex_*                        registered copies of the id_* inputs
//   stall                       hold PC and IF/ID this cycle (combinational)
//   stall_count                 number of load-use bubbles inserted
// ============================================================================
module id_ex_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [63:0] id_ReadData1,
    input  logic [63:0] id_ReadData2,
    input  logic [63:0] id_Imm,
    input  logic [4:0]  id_Rn,
    input  logic [4:0]  id_Rm,
    input  logic [4:0]  id_Rd,
    input  logic        id_MemRead,
    input  logic        id_RegWrite,
    input  logic [5:0]  id_ctrl,
    input  logic        flush,
    output logic        ex_valid,
    output logic [63:0] ex_ReadData1,
    output logic [63:0] ex_ReadData2,
    output logic [63:0] ex_Imm,
    output logic [4:0]  ex_Rn,
    output logic [4:0]  ex_Rm,
    output logic [4:0]  ex_Rd,
    output logic        ex_MemRead,
    output logic        ex_RegWrite,
    output logic [5:0]  ex_ctrl,
    output logic        stall,
    output logic [15:0] stall_count
);

    // X31 is the zero register; a load targeting it never produces a value.
    localparam logic [4:0] XZR = 5'd31;

    logic hazard;
    logic kill_ctrl;  // stall or flush bubble: all controls cleared
    logic squash;     // any cycle whose ID instruction must not take effect

    always_comb begin
        hazard = 1'b0;
        if (ex_valid && ex_MemRead && (ex_Rd != XZR) && id_valid &&
            ((id_Rn == ex_Rd) || (id_Rm == ex_Rd))) begin
            hazard = 1'b1;
        end
    end

    // Flush wins over a hazard: the dependent instruction is being discarded
    // anyway, so there is nothing to wait for.
    assign stall     = hazard & ~flush;
    assign kill_ctrl = stall | flush;
    assign squash    = kill_ctrl | ~id_valid;

    // Data fields always load. On a bubble they are harmless because valid
    // and the side-effecting controls are low. Because a bubble clears
    // ex_MemRead, the hazard cannot persist past one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_ReadData1 <= '0;
            ex_ReadData2 <= '0;
            ex_Imm       <= '0;
            ex_Rn        <= '0;
            ex_Rm        <= '0;
            ex_Rd        <= '0;
            ex_MemRead   <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_ctrl      <= '0;
        end else begin
            ex_valid     <= id_valid & ~kill_ctrl;
            ex_ReadData1 <= id_ReadData1;
            ex_ReadData2 <= id_ReadData2;
            ex_Imm       <= id_Imm;
            ex_Rn        <= id_Rn;
            ex_Rm        <= id_Rm;
            ex_Rd        <= id_Rd;
            ex_MemRead   <= id_MemRead & ~squash;
            ex_RegWrite  <= id_RegWrite & ~squash;
            ex_ctrl      <= kill_ctrl ? 6'd0 : id_ctrl;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating: once all ones, further stalls leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        id_valid;
    logic [63:0] id_ReadData1, id_ReadData2, id_Imm;
    logic [4:0]  id_Rn, id_Rm, id_Rd;
    logic        id_MemRead, id_RegWrite;
    logic [5:0]  id_ctrl;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_ReadData1, ex_ReadData2, ex_Imm;
    logic [4:0]  ex_Rn, ex_Rm, ex_Rd;
    logic        ex_MemRead, ex_RegWrite;
    logic [5:0]  ex_ctrl;
    logic        stall;
    logic [15:0] stall_count;

    id_ex_reg dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2), .id_Imm(id_Imm),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
        .id_MemRead(id_MemRead), .id_RegWrite(id_RegWrite), .id_ctrl(id_ctrl),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2),
        .ex_Imm(ex_Imm), .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .ex_Rd(ex_Rd),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_ctrl(ex_ctrl),
        .stall(stall), .stall_count(stall_count)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt(input int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic vld, input logic [63:0] rd1, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [4:0] rd, input logic mr,
                         input logic rw, input logic [5:0] ctrl, input logic fl);
        id_valid     = vld;
        id_ReadData1 = rd1;
        id_ReadData2 = ~rd1;
        id_Imm       = rd1 + 64'd1;
        id_Rn        = rn;
        id_Rm        = rm;
        id_Rd        = rd;
        id_MemRead   = mr;
        id_RegWrite  = rw;
        id_ctrl      = ctrl;
        flush        = fl;
    endtask

    // Drive one vector, check the combinational stall, clock it, then check
    // the registered outputs against the hand-computed expectation.
    // Data fields are checked only when the vector is not a bubble.
    task automatic apply(input string tag, input logic vld, input logic [63:0] rd1,
                         input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic mr, input logic rw, input logic [5:0] ctrl,
                         input logic fl, input logic e_stall, input logic e_vld,
                         input logic e_mr, input logic e_rw, input logic [5:0] e_ctrl,
                         input logic chk_data, input logic [15:0] e_cnt);
        logic [63:0] e_ctl_word, e_rd1;
        drive(vld, rd1, rn, rm, rd, mr, rw, ctrl, fl);
        #1;
        check({tag, ".stall"}, {63'd0, stall}, {63'd0, e_stall});
        exp_q.push_back({55'd0, e_vld, e_mr, e_rw, e_ctrl});
        exp_q.push_back(rd1);
        @(posedge clk);
        #1;
        if (exp_q.size() < 2) begin
            check({tag, ".sb_empty"}, 64'(exp_q.size()), 64'd2);
        end else begin
            e_ctl_word = exp_q.pop_front();
            e_rd1      = exp_q.pop_front();
            check({tag, ".ctl"}, {55'd0, ex_valid, ex_MemRead, ex_RegWrite, ex_ctrl}, e_ctl_word);
            if (chk_data) begin
                check({tag, ".rd1"}, ex_ReadData1, e_rd1);
                check({tag, ".rd2"}, ex_ReadData2, ~e_rd1);
                check({tag, ".imm"}, ex_Imm, e_rd1 + 64'd1);
                check({tag, ".regs"}, {49'd0, ex_Rn, ex_Rm, ex_Rd}, {49'd0, rn, rm, rd});
            end
        end
        check({tag, ".cnt"}, {48'd0, stall_count}, {48'd0, e_cnt});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        drive(1'b1, 64'hFF, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 6'h3F, 1'b0);
        #3;
        check("rst.valid", {63'd0, ex_valid}, 64'd0);
        check("rst.stall", {63'd0, stall}, 64'd0);
        check("rst.cnt", {48'd0, stall_count}, 64'd0);
        check("rst.data", ex_ReadData1, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        //     tag      vld rd1      rn  rm  rd  mr rw ctrl  fl | stall vld mr rw ectrl data cnt
        apply("pass",  1, 64'h1234,  1,  2,  5, 0, 1, 6'h15, 0,   0,    1,  0, 1, 6'h15, 1, cnt(0));
        apply("ld3",   1, 64'hA,     1,  2,  3, 1, 1, 6'h2A, 0,   0,    1,  1, 1, 6'h2A, 1, cnt(0));
        apply("use3",  1, 64'hB,     3,  4,  6, 0, 1, 6'h01, 0,   1,    0,  0, 0, 6'h00, 0, cnt(1));
        apply("use3b", 1, 64'hB,     3,  4,  6, 0, 1, 6'h01, 0,   0,    1,  0, 1, 6'h01, 1, cnt(1));
        apply("ld31",  1, 64'hC,     0,  0, 31, 1, 1, 6'h2A, 0,   0,    1,  1, 1, 6'h2A, 1, cnt(1));
        apply("use31", 1, 64'hD,    31, 31,  7, 0, 1, 6'h01, 0,   0,    1,  0, 1, 6'h01, 1, cnt(1));
        apply("ld3f",  1, 64'hE,     0,  0,  3, 1, 1, 6'h2A, 0,   0,    1,  1, 1, 6'h2A, 1, cnt(1));
        apply("flush", 1, 64'hF,     3,  0,  8, 0, 1, 6'h01, 1,   0,    0,  0, 0, 6'h00, 0, cnt(1));
        apply("inval", 0, 64'h10,    3,  3,  9, 1, 1, 6'h00, 0,   0,    0,  0, 0, 6'h00, 0, cnt(1));
        // back-to-back dependent loads: one bubble each
        apply("ld4",   1, 64'h20,    0,  0,  4, 1, 1, 6'h2A, 0,   0,    1,  1, 1, 6'h2A, 1, cnt(1));
        apply("ld5a",  1, 64'h21,    4,  0,  5, 1, 1, 6'h2A, 0,   1,    0,  0, 0, 6'h00, 0, cnt(2));
        apply("ld5b",  1, 64'h21,    4,  0,  5, 1, 1, 6'h2A, 0,   0,    1,  1, 1, 6'h2A, 1, cnt(2));
        apply("use5",  1, 64'h22,    0,  5, 10, 0, 1, 6'h01, 0,   1,    0,  0, 0, 6'h00, 0, cnt(3));
        apply("use5b", 1, 64'h22,    0,  5, 10, 0, 1, 6'h01, 0,   0,    1,  0, 1, 6'h01, 1, cnt(3));

        // async reset in the middle of a stall cycle
        apply("ld3r",  1, 64'h30,    0,  0,  3, 1, 1, 6'h2A, 0,   0,    1,  1, 1, 6'h2A, 1, cnt(3));
        drive(1'b1, 64'h31, 5'd3, 5'd0, 5'd11, 1'b0, 1'b1, 6'h01, 1'b0);
        #1;
        check("mid.stall_pre", {63'd0, stall}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst.valid", {63'd0, ex_valid}, 64'd0);
        check("arst.ctl", {55'd0, ex_valid, ex_MemRead, ex_RegWrite, ex_ctrl}, 64'd0);
        check("arst.data", ex_ReadData1 | ex_ReadData2 | ex_Imm, 64'd0);
        check("arst.regs", {49'd0, ex_Rn, ex_Rm, ex_Rd}, 64'd0);
        check("arst.stall", {63'd0, stall}, 64'd0);
        check("arst.cnt", {48'd0, stall_count}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        apply("resume", 1, 64'h31,   3,  0, 11, 0, 1, 6'h01, 0,   0,    1,  0, 1, 6'h01, 1, cnt(0));

        // saturation: preload near the top, then three load-use stalls
`ifdef ID_EX_PERF_CNT_EN
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
`endif
        for (int i = 0; i < 3; i++) begin
            apply("sat.ld",  1, 64'h40, 0, 0, 12, 1, 1, 6'h2A, 0,  0, 1, 1, 1, 6'h2A, 1,
                  PERF ? ((i == 0) ? 16'hFFFE : 16'hFFFF) : 16'd0);
            apply("sat.use", 1, 64'h41, 12, 0, 13, 0, 1, 6'h01, 0, 1, 0, 0, 0, 6'h00, 0,
                  PERF ? 16'hFFFF : 16'd0);
            apply("sat.go",  1, 64'h41, 12, 0, 13, 0, 1, 6'h01, 0, 0, 1, 0, 1, 6'h01, 1,
                  PERF ? 16'hFFFF : 16'd0);
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

endmodule
